inst_queue_mw: RTL and testbench
================================

Name: inst_queue_mw

Overview:
Parametrised multi-wide successor to the single-entry-per-cycle instruction queue.
Sits between I-cache/fetch and decode. Accepts up to ENQ_W fetched instructions per cycle and presents up to DEQ_W oldest instructions to decode per cycle.
Supports flush, stall, partial dequeue and occupancy reporting, enabling superscalar fetch/decode.

Parameters:
DEPTH, 8, number of entries; power of 2, >= max(ENQ_W, DEQ_W)
ENQ_W, 2, enqueue lanes per cycle
DEQ_W, 2, dequeue lanes per cycle
DATA_W, 32, instruction width
PC_W, 32, PC width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries (from hazard control)
stall  in  1  decode stalled; no dequeue this cycle
enq_valid  in  ENQ_W  per-lane valid; must be a contiguous prefix (lane 0 first)
enq_data  in  ENQ_W*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
enq_pc  in  ENQ_W*PC_W  lane i PC
enq_ready  out  1  free entries >= ENQ_W
deq_valid  out  DEQ_W  lane i valid iff count > i
deq_data  out  DEQ_W*DATA_W  lane i = i-th oldest entry
deq_pc  out  DEQ_W*PC_W  lane i PC
deq_take  in  $clog2(DEQ_W+1)  number of lanes consumed this cycle
count  out  $clog2(DEPTH+1)  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (rst=1 at posedge clk): wr_ptr=rd_ptr=0, count=0, all entries cleared to 0. Outputs after reset: empty=1, full=0, enq_ready=1, deq_valid=0, deq_data/deq_pc=0.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit; indexing uses the low bits, so wrap-around is modulo DEPTH.
- Enqueue: n_enq = popcount(enq_valid). Accepted only when enq_ready=1; the transaction is all-or-nothing. Lane i writes to entry (wr_ptr+i) mod DEPTH; wr_ptr advances by n_enq.
- When enq_ready=0, all lanes are dropped and the producer must hold/replay them. A non-prefix enq_valid pattern is illegal.
- Latency: a written entry becomes visible on deq_* the next cycle. There is no same-cycle bypass.
- Dequeue: effective take = stall ? 0 : deq_take; rd_ptr advances by take.
- deq_take > count is illegal. The queue clamps take to count, so rd_ptr never passes wr_ptr.
- enq_ready uses start-of-cycle count only. Slots freed by a same-cycle dequeue do not enable enqueue until the next cycle.
- Simultaneous enq+deq: count_next = count + n_enq_accepted - take.
- Flush has priority over enqueue, dequeue and stall. Next cycle: pointers=0, count=0; entry contents need not be cleared. Flush during rst is overridden by rst.
- deq_data/deq_pc of lanes where deq_valid=0 are don't-care but must not be X after reset.
- There is no state machine. State is pointers plus the entry array; count is derived as wr_ptr - rd_ptr.

Optional Feature:
Macro INST_QUEUE_STATS_EN.
- Defined: adds output port full_cycles (32 bits) counting cycles with full=1 and enq_valid!=0 (fetch backpressure), and output drop_events (32 bits) counting rejected enqueue cycles. Both saturate at max, and reset to 0 on rst only; flush does not clear them.
- Undefined: these ports and counters do not exist; functional behaviour is identical.

Decomposition:
- mips_core_pkg additions: typedef inst_q_entry_t {logic [DATA_W-1:0] data; logic [PC_W-1:0] pc;}; constants INST_Q_MW_DEPTH, INST_Q_ENQ_W, INST_Q_DEQ_W used as defaults.
- One sub-module, inst_q_ptr_ctrl: owns wr_ptr/rd_ptr/count/full/empty/enq_ready, flush, clamp logic and the popcount.
- The parent holds the entry array and the read/write muxing.

Test Plan:
- Reset, then idle: count=0, empty=1, enq_ready=1, deq_valid=2'b00.
- Enqueue 2 cycles of 2 lanes (PC 0x100..0x10C), deq_take=0: count=4. deq_pc lane0=0x100, lane1=0x104. Each enqueue is visible exactly one cycle after its write.
- Fill to DEPTH=8: full=1, enq_ready=0. Enqueue with deq_take=2 in the same cycle: enqueue rejected, count=6 next cycle, then enq_ready=1.
- Wrap: run 20 cycles of 2-in/2-out with incrementing PCs. Every dequeued PC increases by 4 with no gaps or duplicates across the pointer wrap.
- stall=1 with deq_take=2 and count=3: count unchanged. deq_take=2 with count=1: only one entry removed, count=0, no underflow.
- flush=1 together with enq_valid=2'b11 and deq_take=1: next cycle count=0, empty=1. The subsequent enqueue of PC 0x200 appears on deq lane0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared instruction-queue types and default sizing
package mips_core_pkg;

    localparam int INST_Q_MW_DEPTH = 8;
    localparam int INST_Q_ENQ_W    = 2;
    localparam int INST_Q_DEQ_W    = 2;
    localparam int INST_Q_DATA_W   = 32;
    localparam int INST_Q_PC_W     = 32;

    typedef struct packed {
        logic [INST_Q_DATA_W-1:0] data;
        logic [INST_Q_PC_W-1:0]   pc;
    } inst_q_entry_t;

endpackage

// File: rtl/inst_q_ptr_ctrl.sv
// rtl/inst_q_ptr_ctrl.sv - pointer, occupancy and admission control for inst_queue_mw
module inst_q_ptr_ctrl
    import mips_core_pkg::*;
#(
    parameter int DEPTH = INST_Q_MW_DEPTH,
    parameter int ENQ_W = INST_Q_ENQ_W,
    parameter int DEQ_W = INST_Q_DEQ_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         stall,
    input  logic [ENQ_W-1:0]             enq_valid,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_take,
    output logic [$clog2(DEPTH):0]       wr_ptr,
    output logic [$clog2(DEPTH):0]       rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         enq_ready,
    output logic                         enq_fire
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] occ;
    logic [PTR_W-1:0] n_enq;
    logic [PTR_W-1:0] take;

    always_comb begin
        occ   = wr_ptr_q - rd_ptr_q;
        n_enq = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            n_enq = n_enq + PTR_W'(enq_valid[i]);
        end

        // Admission looks only at start-of-cycle occupancy, never at same-cycle frees.
        enq_ready = (occ <= PTR_W'(DEPTH - ENQ_W));
        full      = (occ == PTR_W'(DEPTH));
        empty     = (occ == '0);
        enq_fire  = enq_ready && (|enq_valid) && !flush;

        take = stall ? '0 : PTR_W'(deq_take);
        if (take > occ) begin
            take = occ;
        end

        wr_ptr_d = wr_ptr_q + (enq_fire ? n_enq : '0);
        rd_ptr_d = rd_ptr_q + take;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = CNT_W'(occ);

endmodule

// File: rtl/inst_queue_mw.sv
// rtl/inst_queue_mw.sv - multi-wide fetch-to-decode instruction queue; INST_QUEUE_STATS_EN adds backpressure counters
module inst_queue_mw
    import mips_core_pkg::*;
#(
    parameter int DEPTH  = INST_Q_MW_DEPTH,
    parameter int ENQ_W  = INST_Q_ENQ_W,
    parameter int DEQ_W  = INST_Q_DEQ_W,
    parameter int DATA_W = INST_Q_DATA_W,
    parameter int PC_W   = INST_Q_PC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         stall,
    input  logic [ENQ_W-1:0]             enq_valid,
    input  logic [ENQ_W*DATA_W-1:0]      enq_data,
    input  logic [ENQ_W*PC_W-1:0]        enq_pc,
    output logic                         enq_ready,
    output logic [DEQ_W-1:0]             deq_valid,
    output logic [DEQ_W*DATA_W-1:0]      deq_data,
    output logic [DEQ_W*PC_W-1:0]        deq_pc,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_take,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
`ifdef INST_QUEUE_STATS_EN
    output logic [31:0]                  full_cycles,
    output logic [31:0]                  drop_events,
`endif
    output logic                         empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    logic [IDX_W:0]   wr_ptr;
    logic [IDX_W:0]   rd_ptr;
    logic             enq_fire;
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;

    inst_q_ptr_ctrl #(
        .DEPTH (DEPTH),
        .ENQ_W (ENQ_W),
        .DEQ_W (DEQ_W)
    ) u_ptr_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .enq_valid (enq_valid),
        .deq_take  (deq_take),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .enq_ready (enq_ready),
        .enq_fire  (enq_fire)
    );

    always_comb begin
        entries_d = entries_q;
        widx      = '0;
        if (enq_fire) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (enq_valid[i]) begin
                    widx                 = wr_ptr[IDX_W-1:0] + IDX_W'(i);
                    entries_d[widx].data = enq_data[i*DATA_W +: DATA_W];
                    entries_d[widx].pc   = enq_pc[i*PC_W +: PC_W];
                end
            end
        end
    end

    // Lanes read straight from the array; cleared-on-reset entries keep idle lanes non-X.
    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        deq_pc    = '0;
        ridx      = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            ridx                         = rd_ptr[IDX_W-1:0] + IDX_W'(i);
            deq_valid[i]                 = (count > CNT_W'(i));
            deq_data[i*DATA_W +: DATA_W] = entries_q[ridx].data;
            deq_pc[i*PC_W +: PC_W]       = entries_q[ridx].pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

`ifdef INST_QUEUE_STATS_EN
    logic [31:0] full_cycles_q, full_cycles_d;
    logic [31:0] drop_events_q, drop_events_d;

    always_comb begin
        full_cycles_d = full_cycles_q;
        drop_events_d = drop_events_q;
        if (full && (|enq_valid) && (full_cycles_q != '1)) begin
            full_cycles_d = full_cycles_q + 32'd1;
        end
        if (!enq_ready && (|enq_valid) && (drop_events_q != '1)) begin
            drop_events_d = drop_events_q + 32'd1;
        end
    end

    // Only rst clears the statistics; flush deliberately leaves them running.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_cycles_q <= '0;
            drop_events_q <= '0;
        end else begin
            full_cycles_q <= full_cycles_d;
            drop_events_q <= drop_events_d;
        end
    end

    assign full_cycles = full_cycles_q;
    assign drop_events = drop_events_q;
`endif

endmodule

// File: tb/tb_inst_queue_mw.sv
// tb/tb_inst_queue_mw.sv - scoreboard bench for inst_queue_mw
module tb_inst_queue_mw;
    import mips_core_pkg::*;

    localparam int DEPTH  = INST_Q_MW_DEPTH;
    localparam int ENQ_W  = INST_Q_ENQ_W;
    localparam int DEQ_W  = INST_Q_DEQ_W;
    localparam int DATA_W = INST_Q_DATA_W;
    localparam int PC_W   = INST_Q_PC_W;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        flush = 1'b0;
    logic                        stall = 1'b0;
    logic [ENQ_W-1:0]            enq_valid = '0;
    logic [ENQ_W*DATA_W-1:0]     enq_data = '0;
    logic [ENQ_W*PC_W-1:0]       enq_pc = '0;
    logic                        enq_ready;
    logic [DEQ_W-1:0]            deq_valid;
    logic [DEQ_W*DATA_W-1:0]     deq_data;
    logic [DEQ_W*PC_W-1:0]       deq_pc;
    logic [$clog2(DEQ_W+1)-1:0]  deq_take = '0;
    logic [$clog2(DEPTH+1)-1:0]  count;
    logic                        full;
    logic                        empty;
`ifdef INST_QUEUE_STATS_EN
    logic [31:0]                 full_cycles;
    logic [31:0]                 drop_events;
`endif

    inst_queue_mw dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_pc    (enq_pc),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_pc    (deq_pc),
        .deq_take  (deq_take),
        .count     (count),
        .full      (full),
`ifdef INST_QUEUE_STATS_EN
        .full_cycles (full_cycles),
        .drop_events (drop_events),
`endif
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    bit            mon_en = 1'b0;
    logic [31:0]   next_pc = 32'h0;
    inst_q_entry_t exp_q[$];
    inst_q_entry_t pend_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs; accepted lanes are predicted from the queue's own rules.
    task automatic cyc(input bit f, input bit s, input logic [ENQ_W-1:0] ev, input int tk);
        int n;
        inst_q_entry_t e;
        @(posedge clk);
        #1;
        flush     = f;
        stall     = s;
        enq_valid = ev;
        deq_take  = tk[$clog2(DEQ_W+1)-1:0];
        n = 0;
        for (int i = 0; i < ENQ_W; i++) begin
            enq_data[i*DATA_W +: DATA_W] = $urandom;
            enq_pc[i*PC_W +: PC_W]       = ev[i] ? next_pc + 32'(4 * i) : $urandom;
            if (ev[i]) n++;
        end
        if (!f && n > 0 && exp_q.size() <= DEPTH - ENQ_W) begin
            for (int i = 0; i < n; i++) begin
                e.data = enq_data[i*DATA_W +: DATA_W];
                e.pc   = enq_pc[i*PC_W +: PC_W];
                pend_q.push_back(e);
            end
            next_pc = next_pc + 32'(4 * n);
        end
    endtask

    // Monitor: compares presented lanes against the scoreboard, then retires what decode took.
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            int t;
            sz = exp_q.size();
            chk("count", 64'(count), 64'(sz));
            chk("empty", 64'(empty), 64'(sz == 0));
            chk("full", 64'(full), 64'(sz == DEPTH));
            chk("enq_ready", 64'(enq_ready), 64'(sz <= DEPTH - ENQ_W));
            for (int i = 0; i < DEQ_W; i++) begin
                chk("deq_valid", 64'(deq_valid[i]), 64'(sz > i));
                if (sz > i) begin
                    chk("deq_pc", 64'(deq_pc[i*PC_W +: PC_W]), 64'(exp_q[i].pc));
                    chk("deq_data", 64'(deq_data[i*DATA_W +: DATA_W]), 64'(exp_q[i].data));
                end
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                t = stall ? 0 : int'(deq_take);
                if (t > sz) t = sz;
                for (int i = 0; i < t; i++) void'(exp_q.pop_front());
            end
            while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        end
    end

    initial begin
        int r;
        logic [ENQ_W-1:0] ev;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_deq_valid", 64'(deq_valid), 64'd0);
        chk("reset_deq_data", 64'(deq_data), 64'd0);
        chk("reset_deq_pc", 64'(deq_pc), 64'd0);
        mon_en = 1'b1;

        next_pc = 32'h100;
        cyc(0, 0, 2'b11, 0);
        cyc(0, 0, 2'b11, 0);
        cyc(0, 0, 2'b00, 0);
        @(negedge clk);
        chk("count_after_4", 64'(count), 64'd4);
        chk("lane0_pc", 64'(deq_pc[PC_W-1:0]), 64'h100);
        chk("lane1_pc", 64'(deq_pc[2*PC_W-1:PC_W]), 64'h104);

        cyc(0, 0, 2'b11, 0);
        cyc(0, 0, 2'b11, 0);
        cyc(0, 0, 2'b11, 2);
        @(negedge clk);
        chk("full_reject_count", 64'(count), 64'd8);
        chk("full_flag", 64'(full), 64'd1);
        cyc(0, 0, 2'b00, 0);
        @(negedge clk);
        chk("after_reject_count", 64'(count), 64'd6);
        chk("after_reject_ready", 64'(enq_ready), 64'd1);

        for (int i = 0; i < 20; i++) cyc(0, 0, 2'b11, 2);

        cyc(1, 0, 2'b00, 0);
        cyc(0, 0, 2'b11, 0);
        cyc(0, 0, 2'b01, 0);
        cyc(0, 1, 2'b00, 2);
        @(negedge clk);
        chk("stall_count", 64'(count), 64'd3);
        cyc(0, 0, 2'b00, 2);
        cyc(0, 0, 2'b00, 2);
        cyc(0, 0, 2'b00, 0);
        @(negedge clk);
        chk("clamp_count", 64'(count), 64'd0);

        cyc(0, 0, 2'b11, 0);
        cyc(1, 0, 2'b11, 1);
        next_pc = 32'h200;
        cyc(0, 0, 2'b01, 0);
        @(negedge clk);
        chk("flush_empty", 64'(empty), 64'd1);
        cyc(0, 0, 2'b00, 0);
        @(negedge clk);
        chk("post_flush_pc", 64'(deq_pc[PC_W-1:0]), 64'h200);

        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 2));
            ev = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0), ev,
                int'($urandom_range(0, DEQ_W)));
        end
        cyc(0, 0, 2'b00, 0);
        @(negedge clk);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
